// File: rtl/ysyx_22041207_ifu_pkg.sv
// Shared definitions for the ysyx_22041207 instruction fetch unit:
// FSM state encodings, the nop encoding, the reset PC and the FIFO entry layout.
package ysyx_22041207_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } ifu_state_e;

    // One buffered fetch: instruction word, the PC it was fetched from, access fault.
    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
        logic        err;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Fetch addresses are always word aligned; the low two bits are forced to zero.
    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return pc & ~64'h3;
    endfunction

endpackage

// File: rtl/ysyx_22041207_ifu_fifo.sv
// Small synchronous FIFO holding fetched instructions between memory and decoder.
// Flush empties it in one cycle and wins over a same-cycle push or pop.
module ysyx_22041207_ifu_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign empty     = (count_q == '0);
    assign full      = (count_q == (AW+1)'(DEPTH));
    // A pop frees the slot the push lands in, so push on full is fine alongside a pop.
    assign pop_ok    = pop & ~empty & ~flush;
    assign push_ok   = push & (~full | pop_ok) & ~flush;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage write; contents need no reset because empty gates the head.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: owns the PC, issues in-order fetches under a credit
// limit of DEPTH, buffers responses and hands them to the decoder.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_BOOT   | one cycle after reset release, no fetches issued
// ST_RUN    | fetching: issue while credits allow
// ST_HALTED | halt seen; no new fetches, in-flight ones still drained
module ysyx_22041207_ifu
    import ysyx_22041207_ifu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ireq_valid,
    input  logic        ireq_ready,
    output logic [63:0] ireq_addr,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    input  logic        iresp_err,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        inst_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    ifu_state_e        state_q;
    ifu_state_e        state_d;
    logic [63:0]       pc_q;
    logic [63:0]       req_addr_q;
    logic [63:0]       resp_pc_q;
    logic              pend_q;
    logic [CNT_W-1:0]  outstanding_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic [CNT_W-1:0]  out_nxt;
    logic [CNT_W-1:0]  drop_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_use;
    logic [CNT_W:0]    credit_lim;
    logic [ENTRY_W-1:0] fifo_head;
    fetch_entry_t      head;
    fetch_entry_t      push_entry;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              issue_new;
    logic              accept;
    logic              pend_nxt;
    logic [63:0]       redirect_aligned;

    assign redirect_aligned = align_pc(redirect_pc);

    // A handshake in a redirect cycle is void: the head is being killed.
    assign pop        = inst_valid & inst_ready & ~redirect_valid;
    // Buffered plus in-flight fetches may not exceed DEPTH, counting a slot freed this cycle.
    assign in_use     = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_lim = (CNT_W+1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
    // pc_q advances as soon as a request is first presented; a held request keeps its own address.
    assign issue_new  = (state_q == ST_RUN) & ~pend_q & (in_use < credit_lim);
    assign ireq_valid = pend_q | issue_new;
    assign ireq_addr  = pend_q ? req_addr_q : pc_q;
    assign accept     = ireq_valid & ireq_ready;
    assign pend_nxt   = ireq_valid & ~ireq_ready;
    assign push       = iresp_valid & (drop_cnt_q == '0) & ~redirect_valid;
    assign out_nxt    = outstanding_q + CNT_W'(accept) - CNT_W'(iresp_valid);

    assign push_entry.inst = iresp_data;
    assign push_entry.pc   = resp_pc_q;
    assign push_entry.err  = iresp_err;

    // Next-state decode; halt is sticky because HALTED only leaves through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT:   state_d = ST_RUN;
            ST_RUN:    if (halt) state_d = ST_HALTED;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_BOOT;
        endcase
    end

    // Responses still in flight at a redirect (including a held request) belong to the old path.
    always_comb begin
        drop_nxt = drop_cnt_q;
        if (redirect_valid) begin
            drop_nxt = out_nxt + CNT_W'(pend_nxt);
        end else if (iresp_valid && drop_cnt_q != '0) begin
            drop_nxt = drop_cnt_q - CNT_W'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch PC, held request, in-flight/drop counters and the PC tag of the next kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            req_addr_q    <= '0;
            resp_pc_q     <= RESET_PC;
            pend_q        <= 1'b0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            pend_q        <= pend_nxt;
            outstanding_q <= out_nxt;
            drop_cnt_q    <= drop_nxt;
            if (issue_new) begin
                req_addr_q <= pc_q;
            end
            if (redirect_valid) begin
                pc_q      <= redirect_aligned;
                resp_pc_q <= redirect_aligned;
            end else begin
                if (issue_new) begin
                    pc_q <= pc_q + 64'd4;
                end
                if (push) begin
                    resp_pc_q <= resp_pc_q + 64'd4;
                end
            end
        end
    end

    ysyx_22041207_ifu_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

    assign head       = fifo_head;
    assign inst_valid = ~fifo_empty;
    assign inst       = fifo_empty ? INST_NOP : head.inst;
    assign inst_pc    = fifo_empty ? 64'd0    : head.pc;
    assign inst_err   = fifo_empty ? 1'b0     : head.err;

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Self-checking bench for the fetch unit: a latency-configurable in-order
// memory model plus a scoreboard of the instructions the decoder should see.
module tb_ysyx_22041207_ifu;

    localparam int          DEPTH    = 2;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ireq_valid;
    logic        ireq_ready = 1'b1;
    logic [63:0] ireq_addr;
    logic        iresp_valid = 1'b0;
    logic [31:0] iresp_data = '0;
    logic        iresp_err = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        inst_err;

    always #5 clk = ~clk;

    ysyx_22041207_ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ireq_valid     (ireq_valid),
        .ireq_ready     (ireq_ready),
        .ireq_addr      (ireq_addr),
        .iresp_valid    (iresp_valid),
        .iresp_data     (iresp_data),
        .iresp_err      (iresp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] due;
    } mem_t;

    exp_t        sb[$];
    mem_t        memq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    logic [63:0] err_addr = 64'h0000_0000_8000_0008;
    logic [63:0] exp_next = RESET_PC;
    logic        stale_pend = 1'b0;
    logic [63:0] stale_addr = '0;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    int          req_seen = 0;
    int          err_pop_cnt = 0;
    logic [63:0] err_pop_pc = '0;
    logic [63:0] last_pop_pc = '0;
    logic [63:0] last_acc_addr = '0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_0013;
    endfunction

    // One clock cycle: sample at mid-low phase, update models, advance, then drive memory.
    task automatic cycle();
        exp_t e;
        mem_t m;
        #1;
        n_cmp++;
        if (dut.fifo_count > DEPTH) begin
            n_bad++;
            $display("FAIL fifo_overflow count=%0d limit=%0d", dut.fifo_count, DEPTH);
        end
        if (iresp_valid) begin
            n_cmp++;
            if (dut.outstanding_q == 0) begin
                n_bad++;
                $display("FAIL unsolicited_response outstanding=%0d required>0", dut.outstanding_q);
            end
        end
        if (ireq_valid) req_seen++;
        if (inst_valid && inst_ready && !redirect_valid) begin
            pop_cnt++;
            last_pop_pc = inst_pc;
            if (inst_err) begin
                err_pop_cnt++;
                err_pop_pc = inst_pc;
            end
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pop pc=%h none expected", inst_pc);
            end else begin
                e = sb.pop_front();
                if (inst_pc !== e.pc || inst !== e.inst || inst_err !== e.err) begin
                    n_bad++;
                    $display("FAIL pop_entry got pc=%h inst=%h err=%b want pc=%h inst=%h err=%b",
                             inst_pc, inst, inst_err, e.pc, e.inst, e.err);
                end
            end
        end
        if (ireq_valid && ireq_ready) begin
            acc_cnt++;
            last_acc_addr = ireq_addr;
            m.addr = ireq_addr;
            m.due  = cyc + mem_lat;
            memq.push_back(m);
            n_cmp++;
            if (stale_pend) begin
                if (ireq_addr !== stale_addr) begin
                    n_bad++;
                    $display("FAIL held_addr got=%h want=%h", ireq_addr, stale_addr);
                end
                stale_pend = 1'b0;
            end else begin
                if (ireq_addr !== exp_next) begin
                    n_bad++;
                    $display("FAIL issue_addr got=%h want=%h", ireq_addr, exp_next);
                end
                if (!redirect_valid) begin
                    e.pc   = exp_next;
                    e.inst = inst_of(exp_next);
                    e.err  = (exp_next == err_addr);
                    sb.push_back(e);
                end
                exp_next = exp_next + 64'd4;
            end
        end
        if (redirect_valid) begin
            if (ireq_valid && !ireq_ready && !stale_pend) begin
                n_cmp++;
                if (ireq_addr !== exp_next) begin
                    n_bad++;
                    $display("FAIL pend_addr got=%h want=%h", ireq_addr, exp_next);
                end
                stale_addr = exp_next;
                stale_pend = 1'b1;
            end
            sb.delete();
            exp_next = {redirect_pc[63:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            m = memq.pop_front();
            iresp_valid = 1'b1;
            iresp_data  = inst_of(m.addr);
            iresp_err   = (m.addr == err_addr);
        end else begin
            iresp_valid = 1'b0;
            iresp_data  = '0;
            iresp_err   = 1'b0;
        end
    endtask

    task automatic clear_model();
        sb.delete();
        memq.delete();
        stale_pend     = 1'b0;
        exp_next       = RESET_PC;
        mem_lat        = 1;
        iresp_valid    = 1'b0;
        iresp_data     = '0;
        iresp_err      = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        ireq_ready     = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (ireq_valid !== 1'b0 || inst_valid !== 1'b0 || inst !== NOP ||
            inst_pc !== 64'd0 || inst_err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s got ireq_valid=%b inst_valid=%b inst=%h inst_pc=%h inst_err=%b want 0 0 %h 0 0",
                     tag, ireq_valid, inst_valid, inst, inst_pc, inst_err, NOP);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        clear_model();
        inst_ready = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (ireq_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL boot_no_req got=%b want=0", ireq_valid);
        end
        inst_ready = 1'b1;
        cycle();
        n_cmp++;
        if (ireq_valid !== 1'b1 || ireq_addr !== RESET_PC) begin
            n_bad++;
            $display("FAIL first_req got valid=%b addr=%h want 1 %h", ireq_valid, ireq_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        acc_cnt = 0;
        pop_cnt = 0;
        repeat (10) cycle();
        n_cmp++;
        if (acc_cnt != 10) begin
            n_bad++;
            $display("FAIL stream_accepts got=%0d want=10", acc_cnt);
        end
        n_cmp++;
        if (pop_cnt != 8) begin
            n_bad++;
            $display("FAIL stream_pops got=%0d want=8", pop_cnt);
        end
    endtask

    task automatic test_backpressure();
        inst_ready = 1'b0;
        repeat (5) cycle();
        n_cmp++;
        if (ireq_valid !== 1'b0 || inst_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_flags got ireq_valid=%b inst_valid=%b want 0 1", ireq_valid, inst_valid);
        end
        n_cmp++;
        if (sb.size() != DEPTH || memq.size() != 0) begin
            n_bad++;
            $display("FAIL stall_fill got buffered=%0d inflight=%0d want %0d 0", sb.size(), memq.size(), DEPTH);
        end
        inst_ready = 1'b1;
        pop_cnt = 0;
        repeat (6) cycle();
        n_cmp++;
        if (pop_cnt != 6) begin
            n_bad++;
            $display("FAIL drain_pops got=%0d want=6", pop_cnt);
        end
    endtask

    task automatic test_redirect_drop();
        bit found = 0;
        mem_lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (memq.size() == 2) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL two_outstanding_timeout got=%0d want=2", memq.size());
        end
        redirect_pc    = 64'h0000_0000_8000_0103;
        redirect_valid = 1'b1;
        pop_cnt = 0;
        cycle();
        redirect_valid = 1'b0;
        n_cmp++;
        if (inst_valid !== 1'b0 || pop_cnt != 0) begin
            n_bad++;
            $display("FAIL redirect_kill got inst_valid=%b pops=%0d want 0 0", inst_valid, pop_cnt);
        end
        for (int i = 0; i < 30 && pop_cnt == 0; i++) cycle();
        n_cmp++;
        if (pop_cnt == 0 || last_pop_pc !== 64'h0000_0000_8000_0100) begin
            n_bad++;
            $display("FAIL redirect_first_pc got=%h pops=%0d want 0000000080000100", last_pop_pc, pop_cnt);
        end
        mem_lat = 1;
        repeat (6) cycle();
    endtask

    task automatic test_redirect_stall();
        logic [63:0] held;
        repeat (3) cycle();
        ireq_ready = 1'b0;
        cycle();
        held = exp_next;
        n_cmp++;
        if (ireq_valid !== 1'b1 || ireq_addr !== held) begin
            n_bad++;
            $display("FAIL stall_req got valid=%b addr=%h want 1 %h", ireq_valid, ireq_addr, held);
        end
        redirect_pc    = 64'h0000_0000_8000_0202;
        redirect_valid = 1'b1;
        pop_cnt = 0;
        cycle();
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (ireq_valid !== 1'b1 || ireq_addr !== held) begin
                n_bad++;
                $display("FAIL stall_hold got valid=%b addr=%h want 1 %h", ireq_valid, ireq_addr, held);
            end
            if (i == 0) cycle();
        end
        ireq_ready = 1'b1;
        cycle();
        cycle();
        n_cmp++;
        if (last_acc_addr !== 64'h0000_0000_8000_0200) begin
            n_bad++;
            $display("FAIL stall_next_req got=%h want 0000000080000200", last_acc_addr);
        end
        for (int i = 0; i < 20 && pop_cnt == 0; i++) cycle();
        n_cmp++;
        if (pop_cnt == 0 || last_pop_pc !== 64'h0000_0000_8000_0200) begin
            n_bad++;
            $display("FAIL stall_first_pc got=%h pops=%0d want 0000000080000200", last_pop_pc, pop_cnt);
        end
    endtask

    task automatic test_fetch_err();
        redirect_pc    = 64'h0000_0000_8000_0005;
        redirect_valid = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        pop_cnt     = 0;
        err_pop_cnt = 0;
        for (int i = 0; i < 30 && pop_cnt < 4; i++) cycle();
        n_cmp++;
        if (err_pop_cnt != 1 || err_pop_pc !== 64'h0000_0000_8000_0008) begin
            n_bad++;
            $display("FAIL err_tag got count=%0d pc=%h want 1 0000000080000008", err_pop_cnt, err_pop_pc);
        end
    endtask

    task automatic test_halt();
        bit found = 0;
        mem_lat = 3;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (memq.size() == 1) found = 1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL one_outstanding_timeout got=%0d want=1", memq.size());
        end
        halt = 1'b1;
        cycle();
        halt = 1'b0;
        req_seen = 0;
        acc_cnt  = 0;
        pop_cnt  = 0;
        repeat (10) cycle();
        n_cmp++;
        if (req_seen != 0 || acc_cnt != 0) begin
            n_bad++;
            $display("FAIL halt_no_req got req_cycles=%0d accepts=%0d want 0 0", req_seen, acc_cnt);
        end
        n_cmp++;
        if (pop_cnt == 0 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL halt_drain got pops=%0d left=%0d want >0 0", pop_cnt, sb.size());
        end
        redirect_pc    = 64'h0000_0000_8000_1000;
        redirect_valid = 1'b1;
        cycle();
        redirect_valid = 1'b0;
        req_seen = 0;
        repeat (5) cycle();
        n_cmp++;
        if (req_seen != 0 || inst_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL halted_redirect got req_cycles=%0d inst_valid=%b want 0 0", req_seen, inst_valid);
        end
    endtask

    task automatic test_async_reset();
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        inst_ready = 1'b1;
        repeat (6) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_values");
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pop_cnt = 0;
        repeat (7) cycle();
        n_cmp++;
        if (pop_cnt != 4) begin
            n_bad++;
            $display("FAIL restart_pops got=%0d want=4", pop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_stall();
        test_fetch_err();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

endmodule
